// File: rtl/capture_buffer_ctrl_pkg.sv
// Shared types and sizing for the capture buffer controller and its helpers.
package capture_pkg;

    localparam int unsigned DEPTH = 6144;
    localparam int unsigned AW    = 13;
    localparam int unsigned CW    = 14;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        TRIGGERED,
        DONE,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD
    } state_t;

    // Post-trigger length can never exceed one buffer's worth minus the trigger sample.
    function automatic logic [CW-1:0] clamp_post(input logic [CW-1:0] v);
        return (v > CW'(DEPTH - 1)) ? CW'(DEPTH - 1) : v;
    endfunction

endpackage

// File: rtl/capture_buffer_ctrl_wrap_counter.sv
// Address counter over 0..DEPTH-1 with synchronous load and compare-and-wrap.
module wrap_counter
    import capture_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [AW-1:0] i_load_val,
    input  logic          i_inc,
    output logic [AW-1:0] o_count,
    output logic          o_terminal
);

    logic [AW-1:0] r_count;

    assign o_count    = r_count;
    assign o_terminal = (r_count == AW'(DEPTH - 1));

    // Load has priority; increments wrap at DEPTH-1 so the upper address range is never reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= o_terminal ? '0 : r_count + AW'(1);
        end
    end

endmodule

// File: rtl/capture_buffer_ctrl.sv
// Circular capture into the 6144x9 sample RAM, post-trigger countdown, and
// oldest-first readout over a valid/ack handshake.
module capture_buffer_ctrl
    import capture_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET,
    input  logic          arm,
    input  logic          abort,
    input  logic          sample_valid,
    input  logic [7:0]    sample_data,
    input  logic          sample_flag,
    input  logic          trigger,
    input  logic [CW-1:0] post_count,
    input  logic          rd_start,
    input  logic          rd_ack,
    input  logic [7:0]    ram_dout,
    input  logic          ram_doutp,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic          ram_en,
    output logic [7:0]    ram_din,
    output logic          ram_dinp,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    output logic          rd_flag,
    output logic          armed,
    output logic          capture_done,
    output logic          readout_done
);

    state_t        r_state, w_next_state;
    logic [CW-1:0] r_post, r_remaining;
    logic          r_filled;
    logic [AW-1:0] r_ram_addr;
    logic          r_ram_we, r_ram_en, r_ram_dinp;
    logic [7:0]    r_ram_din, r_rd_data;
    logic          r_rd_valid, r_rd_flag, r_readout_done;

    logic          w_accept, w_wptr_clear, w_post_load, w_post_dec;
    logic          w_rd_load, w_rd_step, w_rd_capture, w_rd_end, w_rd_issue;
    logic [AW-1:0] w_wptr, w_rptr, w_rptr_next, w_rd_load_ptr, w_rd_issue_addr;
    logic          w_wptr_term, w_rptr_term;
    logic [CW-1:0] w_post_clamped, w_rd_load_len;

    wrap_counter u_wptr (
        .clk        (CLK),
        .rst        (RESET),
        .i_load     (w_wptr_clear),
        .i_load_val ('0),
        .i_inc      (w_accept),
        .o_count    (w_wptr),
        .o_terminal (w_wptr_term)
    );

    wrap_counter u_rptr (
        .clk        (CLK),
        .rst        (RESET),
        .i_load     (w_rd_load),
        .i_load_val (w_rd_load_ptr),
        .i_inc      (w_rd_step),
        .o_count    (w_rptr),
        .o_terminal (w_rptr_term)
    );

    assign w_post_clamped = clamp_post(post_count);
    assign w_rd_load_ptr  = r_filled ? w_wptr : '0;
    assign w_rd_load_len  = r_filled ? CW'(DEPTH) : CW'(w_wptr);
    assign w_rptr_next    = w_rptr_term ? '0 : w_rptr + AW'(1);

    // The RAM read is launched on the transition into RD_ISSUE so that EN/ADDR are
    // on the pins during RD_ISSUE and DOUT is settled by the end of RD_WAIT.
    assign w_rd_issue      = (w_rd_load && (w_rd_load_len != '0)) ||
                             (w_rd_step && (r_remaining != CW'(1)));
    assign w_rd_issue_addr = w_rd_load ? w_rd_load_ptr : w_rptr_next;

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control strobes; abort overrides every other request.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_wptr_clear = 1'b0;
        w_post_load  = 1'b0;
        w_post_dec   = 1'b0;
        w_rd_load    = 1'b0;
        w_rd_step    = 1'b0;
        w_rd_capture = 1'b0;
        w_rd_end     = 1'b0;
        if (abort) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (arm) begin
                        w_wptr_clear = 1'b1;
                        w_next_state = ARMED;
                    end
                end
                ARMED: begin
                    if (sample_valid) begin
                        w_accept = 1'b1;
                        if (trigger) begin
                            w_post_load  = 1'b1;
                            w_next_state = (w_post_clamped == '0) ? DONE : TRIGGERED;
                        end
                    end
                end
                TRIGGERED: begin
                    if (sample_valid) begin
                        w_accept   = 1'b1;
                        w_post_dec = 1'b1;
                        if (r_post == CW'(1)) begin
                            w_next_state = DONE;
                        end
                    end
                end
                DONE: begin
                    if (arm) begin
                        w_wptr_clear = 1'b1;
                        w_next_state = ARMED;
                    end else if (rd_start) begin
                        w_rd_load    = 1'b1;
                        w_next_state = RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (r_remaining == '0) begin
                        w_rd_end     = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    w_rd_capture = 1'b1;
                    w_next_state = RD_HOLD;
                end
                RD_HOLD: begin
                    if (rd_ack) begin
                        w_rd_step    = 1'b1;
                        w_next_state = RD_ISSUE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Registered RAM port, counters, filled flag and readout handshake.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ram_addr     <= '0;
            r_ram_we       <= 1'b0;
            r_ram_en       <= 1'b0;
            r_ram_din      <= '0;
            r_ram_dinp     <= 1'b0;
            r_filled       <= 1'b0;
            r_post         <= '0;
            r_remaining    <= '0;
            r_rd_valid     <= 1'b0;
            r_rd_data      <= '0;
            r_rd_flag      <= 1'b0;
            r_readout_done <= 1'b0;
        end else begin
            r_ram_we       <= w_accept;
            r_ram_en       <= w_accept | w_rd_issue;
            r_readout_done <= w_rd_end;
            if (w_accept) begin
                r_ram_addr <= w_wptr;
                r_ram_din  <= sample_data;
                r_ram_dinp <= sample_flag;
            end else if (w_rd_issue) begin
                r_ram_addr <= w_rd_issue_addr;
            end
            if (w_wptr_clear) begin
                r_filled <= 1'b0;
            end else if (w_accept && w_wptr_term) begin
                r_filled <= 1'b1;
            end
            if (w_post_load) begin
                r_post <= w_post_clamped;
            end else if (w_post_dec) begin
                r_post <= r_post - CW'(1);
            end
            if (w_rd_load) begin
                r_remaining <= w_rd_load_len;
            end else if (w_rd_step) begin
                r_remaining <= r_remaining - CW'(1);
            end
            if (abort || w_rd_step) begin
                r_rd_valid <= 1'b0;
            end else if (w_rd_capture) begin
                r_rd_valid <= 1'b1;
            end
            if (w_rd_capture) begin
                r_rd_data <= ram_dout;
                r_rd_flag <= ram_doutp;
            end
        end
    end

    assign ram_addr     = r_ram_addr;
    assign ram_we       = r_ram_we;
    assign ram_en       = r_ram_en;
    assign ram_din      = r_ram_din;
    assign ram_dinp     = r_ram_dinp;
    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign rd_flag      = r_rd_flag;
    assign armed        = (r_state == ARMED) || (r_state == TRIGGERED);
    assign capture_done = (r_state == DONE);
    assign readout_done = r_readout_done;

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// Bench for capture_buffer_ctrl: RAM model, scenario tasks, sample-history reference.
module tb_capture_buffer_ctrl;

    localparam int DEPTH = 6144;
    localparam int MAXP  = DEPTH - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm, abort, sample_valid, sample_flag, trigger, rd_start, rd_ack;
    logic [7:0]  sample_data;
    logic [13:0] post_count;
    logic [7:0]  ram_dout;
    logic        ram_doutp;
    logic [12:0] ram_addr;
    logic        ram_we, ram_en, ram_dinp;
    logic [7:0]  ram_din;
    logic        rd_valid, rd_flag, armed, capture_done, readout_done;
    logic [7:0]  rd_data;

    logic [8:0]  mem [0:DEPTH-1];
    logic [8:0]  stim[$];
    logic [8:0]  exp_q[$];
    int          we_count = 0;
    int          bad_addr = 0;
    int          n_total  = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    capture_buffer_ctrl dut (
        .CLK(clk), .RESET(rst), .arm(arm), .abort(abort),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_flag(sample_flag),
        .trigger(trigger), .post_count(post_count), .rd_start(rd_start), .rd_ack(rd_ack),
        .ram_dout(ram_dout), .ram_doutp(ram_doutp), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_en(ram_en), .ram_din(ram_din), .ram_dinp(ram_dinp), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_flag(rd_flag), .armed(armed), .capture_done(capture_done),
        .readout_done(readout_done)
    );

    // Synchronous single-port RAM: write when WE, otherwise registered read when EN.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_addr >= 13'(DEPTH)) begin
                bad_addr++;
            end else if (ram_we) begin
                mem[ram_addr] <= {ram_dinp, ram_din};
            end else begin
                {ram_doutp, ram_dout} <= mem[ram_addr];
            end
        end
        if (ram_we) we_count++;
    end

    task automatic idle_inputs();
        arm = 0; abort = 0; sample_valid = 0; sample_flag = 0; sample_data = 0;
        trigger = 0; rd_start = 0; rd_ack = 0; post_count = 0;
    endtask

    // Feed stim[] after an arm pulse; reference: capture ends at trig+min(post,DEPTH-1),
    // readout is the newest min(len, DEPTH) samples up to that point.
    task automatic run_capture(input int trig, input int post, input int gap_max, input bit rand_arm, input string tag);
        int n, exp_done, first_done, last, we0, start;
        n = stim.size();
        exp_done = trig + ((post > MAXP) ? MAXP : post);
        we0 = we_count;
        post_count = 14'(post);
        arm = 1; @(negedge clk); arm = 0;
        n_total++;
        if (armed !== 1'b1) $display("FAIL %s armed: got %b want 1", tag, armed); else n_pass++;
        first_done = -1; last = -1;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                sample_valid = 0; trigger = 1'($urandom_range(1, 0));
                @(negedge clk);
                if (capture_done && first_done < 0) first_done = last;
            end
            sample_valid = 1; {sample_flag, sample_data} = stim[i];
            trigger = (i == trig) ? 1'b1 : ((i > trig) ? 1'($urandom_range(1, 0)) : 1'b0);
            arm = rand_arm && (i <= exp_done) && ($urandom_range(7, 0) == 0);
            @(negedge clk);
            arm = 0; last = i;
            if (capture_done && first_done < 0) first_done = last;
        end
        sample_valid = 0; trigger = 0;
        @(negedge clk); @(negedge clk);
        if (capture_done && first_done < 0) first_done = last;
        n_total++;
        if (first_done !== exp_done) $display("FAIL %s done_point: got %0d want %0d", tag, first_done, exp_done); else n_pass++;
        n_total++;
        if (we_count - we0 !== exp_done + 1) $display("FAIL %s write_count: got %0d want %0d", tag, we_count - we0, exp_done + 1); else n_pass++;
        exp_q.delete();
        start = (exp_done + 1 > DEPTH) ? exp_done + 1 - DEPTH : 0;
        for (int j = start; j <= exp_done; j++) exp_q.push_back(stim[j]);
    endtask

    // Drain the buffer and compare against exp_q; optional 20-cycle stall at one byte.
    task automatic run_readout(input int stall_at, input bit hold_ack, input string tag);
        int errs, stall_err, spacing_err, got_n, w, first_bad;
        logic [8:0] got, held;
        logic [8:0] want_bad, got_bad;
        bit timeout;
        errs = 0; stall_err = 0; spacing_err = 0; got_n = 0; timeout = 0; first_bad = -1;
        want_bad = '0; got_bad = '0;
        rd_start = 1; rd_ack = hold_ack; @(negedge clk); rd_start = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            w = 0;
            while (!rd_valid && w < 20) begin @(negedge clk); w++; end
            if (!rd_valid) begin timeout = 1; break; end
            if (hold_ack && k > 0 && w != 2) spacing_err++;
            got = {rd_flag, rd_data};
            if (got !== exp_q[k]) begin
                errs++;
                if (first_bad < 0) begin first_bad = k; want_bad = exp_q[k]; got_bad = got; end
            end
            if (k == stall_at) begin
                rd_ack = 0; held = got;
                repeat (20) begin
                    @(negedge clk);
                    if (rd_valid !== 1'b1 || {rd_flag, rd_data} !== held) stall_err++;
                end
            end
            rd_ack = 1; @(negedge clk); if (!hold_ack) rd_ack = 0;
            got_n++;
        end
        w = 0;
        while (!readout_done && w < 6) begin
            if (rd_valid) spacing_err++;
            @(negedge clk); w++;
        end
        rd_ack = 0;
        n_total++;
        if (timeout || got_n !== exp_q.size()) $display("FAIL %s readout_len: got %0d want %0d", tag, got_n, exp_q.size()); else n_pass++;
        n_total++;
        if (errs !== 0) $display("FAIL %s readout_data: %0d bad, first at %0d got %h want %h", tag, errs, first_bad, got_bad, want_bad); else n_pass++;
        n_total++;
        if (readout_done !== 1'b1) $display("FAIL %s readout_done: got %b want 1", tag, readout_done); else n_pass++;
        @(negedge clk);
        n_total++;
        if ({readout_done, capture_done, rd_valid} !== 3'b000) $display("FAIL %s after_readout: got %b want 000", tag, {readout_done, capture_done, rd_valid}); else n_pass++;
        if (stall_at >= 0) begin
            n_total++;
            if (stall_err !== 0) $display("FAIL %s stall_hold: got %0d glitches want 0", tag, stall_err); else n_pass++;
        end
        n_total++;
        if (spacing_err !== 0) $display("FAIL %s byte_spacing: got %0d errors want 0", tag, spacing_err); else n_pass++;
    endtask

    task automatic test_reset();
        idle_inputs(); rst = 1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({ram_addr, ram_we, ram_en, ram_din, ram_dinp, rd_valid, rd_data, rd_flag, armed, capture_done, readout_done} !== '0)
            $display("FAIL reset_outputs: got nonzero outputs addr=%h we=%b en=%b", ram_addr, ram_we, ram_en); else n_pass++;
        rst = 0; @(negedge clk);
        sample_valid = 1; trigger = 1; rd_start = 1; @(negedge clk); idle_inputs(); @(negedge clk);
        n_total++;
        if ({armed, capture_done, ram_we, we_count} !== 35'd0) $display("FAIL idle_ignores: got armed=%b done=%b writes=%0d want 0", armed, capture_done, we_count); else n_pass++;
    endtask

    task automatic test_short();
        stim.delete();
        for (int i = 0; i < 10; i++) stim.push_back(9'(i));
        run_capture(5, 4, 0, 0, "short");
        run_readout(3, 0, "short");
    endtask

    task automatic test_reset_mid_readout();
        int w;
        stim.delete();
        for (int i = 0; i < 5; i++) stim.push_back(9'(8'h40 + i));
        run_capture(0, 4, 1, 0, "rstmid");
        rd_start = 1; @(negedge clk); rd_start = 0;
        w = 0;
        while (!rd_valid && w < 20) begin @(negedge clk); w++; end
        n_total++;
        if (rd_valid !== 1'b1) $display("FAIL rstmid reach_hold: got %b want 1", rd_valid); else n_pass++;
        rst = 1; #1;
        n_total++;
        if ({rd_valid, ram_en, capture_done, armed} !== 4'b0000) $display("FAIL rstmid outputs: got %b want 0000", {rd_valid, ram_en, capture_done, armed}); else n_pass++;
        @(negedge clk); rst = 0; @(negedge clk);
    endtask

    task automatic test_zero_post();
        stim.delete();
        stim.push_back(9'h0A5);
        for (int i = 0; i < 3; i++) stim.push_back(9'(9'h111 + i));
        run_capture(0, 0, 0, 0, "zeropost");
        run_readout(-1, 0, "zeropost");
    endtask

    task automatic test_abort();
        int we0, w;
        // Abort while the readout is holding a byte.
        stim.delete();
        for (int i = 0; i < 5; i++) stim.push_back(9'($urandom_range(511, 0)));
        run_capture(2, 2, 0, 0, "abort_rd");
        rd_start = 1; @(negedge clk); rd_start = 0;
        w = 0;
        while (!rd_valid && w < 20) begin @(negedge clk); w++; end
        abort = 1; rd_ack = 1; @(negedge clk); abort = 0; rd_ack = 0;
        n_total++;
        if ({rd_valid, capture_done, ram_en} !== 3'b000) $display("FAIL abort_rd outputs: got %b want 000", {rd_valid, capture_done, ram_en}); else n_pass++;
        // Abort while TRIGGERED, concurrent with a sample.
        we0 = we_count;
        post_count = 100; arm = 1; @(negedge clk); arm = 0;
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1; sample_data = 8'(i); trigger = (i == 1); @(negedge clk);
        end
        trigger = 1; abort = 1; @(negedge clk); abort = 0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        sample_valid = 0; trigger = 0; @(negedge clk);
        n_total++;
        if (we_count - we0 !== 3) $display("FAIL abort_trig writes: got %0d want 3", we_count - we0); else n_pass++;
        n_total++;
        if ({armed, capture_done} !== 2'b00) $display("FAIL abort_trig state: got %b want 00", {armed, capture_done}); else n_pass++;
        // Arm and abort in the same cycle stay in IDLE.
        we0 = we_count;
        arm = 1; abort = 1; @(negedge clk); arm = 0; abort = 0;
        n_total++;
        if (armed !== 1'b0) $display("FAIL arm_abort armed: got %b want 0", armed); else n_pass++;
        sample_valid = 1; trigger = 1; repeat (3) @(negedge clk); sample_valid = 0; trigger = 0; @(negedge clk);
        n_total++;
        if (we_count - we0 !== 0) $display("FAIL arm_abort writes: got %0d want 0", we_count - we0); else n_pass++;
    endtask

    task automatic test_random();
        int trig, post, extra;
        for (int it = 0; it < 4; it++) begin
            trig = $urandom_range(20, 0); post = $urandom_range(25, 0); extra = $urandom_range(4, 1);
            stim.delete();
            for (int i = 0; i < trig + post + 1 + extra; i++) stim.push_back(9'($urandom_range(511, 0)));
            run_capture(trig, post, 2, 1, "random");
            run_readout(-1, 1'(it & 1), "random");
        end
    endtask

    task automatic test_wrap();
        stim.delete();
        for (int i = 0; i < 6200; i++) stim.push_back({1'(i & 1), 8'(i % 256)});
        run_capture(6150, 49, 0, 0, "wrap");
        n_total++;
        if (exp_q[0] !== 9'h038) $display("FAIL wrap first_oldest: got %h want 038", exp_q[0]); else n_pass++;
        run_readout(-1, 1, "wrap");
        n_total++;
        if (bad_addr !== 0) $display("FAIL wrap addr_range: got %0d out-of-range want 0", bad_addr); else n_pass++;
    endtask

    task automatic test_clamp();
        stim.delete();
        for (int i = 0; i < DEPTH + 3; i++) stim.push_back(9'($urandom_range(511, 0)));
        run_capture(0, 16383, 0, 0, "clamp");
        run_readout(-1, 1, "clamp");
        n_total++;
        if (bad_addr !== 0) $display("FAIL clamp addr_range: got %0d out-of-range want 0", bad_addr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_short();
        test_reset_mid_readout();
        test_zero_post();
        test_abort();
        test_random();
        test_wrap();
        test_clamp();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/capture_buffer_ctrl.md
Name: capture_buffer_ctrl

Overview:
- Capture/readout controller that sits directly upstream of the 6144 x 9-bit sample RAM, BRAM6k9bit.
- Drives the RAM's ADDR, WE, EN, DIN and DINP ports:
  - Capture: writes qualified samples into a circular buffer.
  - Trigger: counts a programmable number of post-trigger samples after the trigger.
  - Readout: reads the captured window back, oldest sample first, over a valid/ack handshake to the host-side serialiser.

Parameters:
- DEPTH, 6144, number of RAM locations; not a power of two.
- AW, 13, RAM address width.
- CW, 14, width of the sample/post-trigger counters; must hold DEPTH.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle pulse: start a new capture.
- abort  in  1  single-cycle pulse: return to IDLE from any state.
- sample_valid  in  1  sample strobe.
- sample_data  in  8  sample byte.
- sample_flag  in  1  ninth bit; stored in parity.
- trigger  in  1  trigger condition, qualified by sample_valid.
- post_count  in  CW  number of samples to store after the trigger sample.
- rd_start  in  1  single-cycle pulse: begin readout (honoured in DONE only).
- rd_ack  in  1  consumer accepts rd_data.
- ram_dout  in  8  RAM DOUT.
- ram_doutp  in  1  RAM DOUTP.
- ram_addr  out  AW  RAM ADDR.
- ram_we  out  1  RAM WE.
- ram_en  out  1  RAM EN.
- ram_din  out  8  RAM DIN.
- ram_dinp  out  1  RAM DINP.
- rd_valid  out  1  rd_data/rd_flag are valid.
- rd_data  out  8  readout byte.
- rd_flag  out  1  readout ninth bit.
- armed  out  1  high in ARMED or TRIGGERED.
- capture_done  out  1  high in DONE.
- readout_done  out  1  one-cycle pulse at the end of readout.

Behaviour:
- Reset:
  - Asynchronous; state goes to IDLE.
  - All outputs 0; wptr, rptr and counters 0; the filled flag is cleared.
- RAM port signals are registered. A sample accepted in cycle N produces ram_addr, ram_din, ram_dinp, ram_we=1 and ram_en=1 in cycle N+1. ram_we and ram_en deassert in the next cycle unless another sample is accepted.
- States:
  - IDLE:
    - arm: go to ARMED, clear wptr and filled.
    - Other inputs are ignored.
  - ARMED:
    - Each sample_valid writes at wptr; wptr increments.
    - At DEPTH-1, wptr wraps to 0 and filled is set.
    - sample_valid & trigger: that sample is written.
    - The post counter loads min(post_count, DEPTH-1).
    - If the loaded value is 0, go to DONE; otherwise go to TRIGGERED.
  - TRIGGERED:
    - Each sample_valid writes and decrements the post counter.
    - When the counter reaches 0 after a write, go to DONE.
    - trigger is ignored.
  - DONE:
    - capture_done=1.
    - rd_start: rptr = filled ? wptr : 0; remaining = filled ? DEPTH : wptr; go to RD_ISSUE.
    - arm: restart capture and go to ARMED.
  - RD_ISSUE:
    - If remaining==0, pulse readout_done and go to IDLE.
    - Otherwise drive ram_addr=rptr, ram_en=1, ram_we=0; go to RD_WAIT.
  - RD_WAIT:
    - The RAM output, including its internal bank mux, is valid one cycle after EN.
    - Register ram_dout/ram_doutp into rd_data/rd_flag, set rd_valid=1, go to RD_HOLD.
  - RD_HOLD:
    - rd_valid stays high and rd_data is stable until rd_ack.
    - On rd_ack: rd_valid=0; rptr increments with wrap DEPTH-1 to 0; remaining decrements; go to RD_ISSUE.
- Throughput: one byte per 3 cycles with rd_ack held high.
- abort:
  - Goes to IDLE from any state in the next cycle.
  - rd_valid, ram_we and ram_en are cleared.
  - abort wins over arm, rd_start and trigger in the same cycle.
- arm in ARMED, TRIGGERED or a readout state: ignored.
- sample_valid outside ARMED/TRIGGERED: ignored; no RAM write.
- Address arithmetic: a compare-and-wrap at DEPTH-1, never modulo-2^AW. Addresses 6144..8191 must never be driven.
- Readout length is DEPTH when filled, otherwise the number of samples written.

Decomposition:
- Shared package (capture_pkg):
  - State enum: IDLE, ARMED, TRIGGERED, DONE, RD_ISSUE, RD_WAIT, RD_HOLD.
  - Constants: DEPTH=6144, AW=13, CW=14.
- One natural sub-module: wrap_counter (load, increment, wrap at DEPTH-1, terminal flag). It is instantiated twice, for wptr and rptr.
- The FSM, post counter and output registers stay in capture_buffer_ctrl.

Test Plan:
- Reset mid-readout (RESET high in RD_HOLD):
  - rd_valid=0, ram_en=0 immediately; state IDLE; capture_done=0.
- Short capture, no wrap:
  - Stimulus: arm; 10 samples 0x00..0x09, trigger on 0x05, post_count=4; rd_start; ack every byte.
  - Response: capture_done after 0x09; readout returns 0x00..0x09 in order (10 bytes), then a readout_done pulse.
- Wrap:
  - Stimulus: arm; 6200 samples (byte = index mod 256, flag = index[0]); trigger at index 6150, post_count=49.
  - Response: DONE after index 6199; readout returns 6144 bytes starting at index 56 (0x38), flags matching; addresses seen all in 0..6143.
- Zero post-trigger:
  - Stimulus: post_count=0, trigger on the first sample 0xA5.
  - Response: immediate DONE; readout returns exactly 1 byte, 0xA5.
- Post-trigger clamp:
  - Stimulus: post_count=16383.
  - Response: the counter loads 6143; DONE after 6143 further samples.
- Handshake stall and abort:
  - Stimulus: hold rd_ack low for 20 cycles; then abort while TRIGGERED; then arm and abort in the same cycle.
  - Response: rd_data stable and rd_valid held during the stall; after the abort, no further ram_we pulses; the arm+abort cycle ends in IDLE.
